// File: rtl/pipe_buf.sv
// pipe_buf -- elastic pipeline register for core stage boundaries.
//
// A DEPTH-entry circular buffer holding one DATA_W-wide packed payload per
// entry, with a valid/ready handshake on both sides, a stage hold, and a
// synchronous flush that discards every stored entry. When no entry is being
// presented, the output carries BUBBLE_VAL (a NOP on instruction lanes).
//
// Optional feature macro: PIPE_BUF_BYPASS_EN
//   When defined, a payload that arrives while the buffer is empty is shown
//   on the output combinationally. If downstream takes it in the same cycle,
//   it is never stored.
//
// Ports:
//   clk_i        clock; all state changes on the rising edge
//   rst_n_i      asynchronous active-low reset (pointers and count only)
//   hold_i       stall; freezes both handshake sides
//   flush_i      synchronous flush; discards all entries; overrides hold_i
//   in_valid_i   upstream payload valid
//   in_ready_o   buffer accepts a payload this cycle
//   in_data_i    upstream payload
//   out_valid_o  payload presented downstream
//   out_ready_i  downstream accepts this cycle
//   out_data_o   head payload, or BUBBLE_VAL
//   count_o      number of stored entries (registered)
module pipe_buf #(
    parameter int                DATA_W     = 32,
    parameter int                DEPTH      = 2,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = DATA_W'(32'h0000_0013),
    localparam int               CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              hold_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CNT_W-1:0]  count_o
);

    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic active;
    logic empty;
    logic bypass;
    logic push;
    logic pop;
    logic store;
    logic pop_mem;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        active = !hold_i && !flush_i;
        empty  = (count_q == '0);

        // Depends only on local state and control, never on out_ready_i, so a
        // full buffer refuses a push even when a pop happens the same cycle.
        in_ready_o = rst_n_i && active && (count_q != FULL_CNT);

`ifdef PIPE_BUF_BYPASS_EN
        bypass = rst_n_i && active && empty && in_valid_i;
`else
        bypass = 1'b0;
`endif

        out_valid_o = (active && !empty) || bypass;
        out_data_o  = BUBBLE_VAL;
        if (active && !empty) begin
            out_data_o = mem_q[rd_ptr_q];
        end else if (bypass) begin
            out_data_o = in_data_i;
        end

        push = in_valid_i && in_ready_o;
        pop  = out_valid_o && out_ready_i;

        // A bypassed payload taken downstream in the same cycle is not stored;
        // a pop only consumes storage when there was a stored head.
        store   = push && !(bypass && out_ready_i);
        pop_mem = pop && !empty;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (store) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop_mem) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(store) - CNT_W'(pop_mem);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage is deliberately left unreset; only occupancy matters.
    always_ff @(posedge clk_i) begin
        if (store) begin
            mem_q[wr_ptr_q] <= in_data_i;
        end
    end

    assign count_o = count_q;

endmodule

// File: tb/tb_pipe_buf.sv
// Testbench for pipe_buf: DEPTH=2 instance (stream, full-with-pop, hold,
// flush, reset, bypass) and DEPTH=3 instance (fill and pointer wrap).
module tb_pipe_buf;

    logic clk = 1'b0;
    always #5 clk = ~clk;

`ifdef PIPE_BUF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        rst_n, hold, flush;
    logic [31:0] in_data;

    logic        a_iv, a_ir, a_ov, a_or;
    logic [31:0] a_od;
    logic [1:0]  a_cnt;

    logic        b_iv, b_ir, b_ov, b_or;
    logic [31:0] b_od;
    logic [2:0]  b_cnt;

    pipe_buf #(.DATA_W(32), .DEPTH(2)) u_dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .hold_i(hold), .flush_i(flush),
        .in_valid_i(a_iv), .in_ready_o(a_ir), .in_data_i(in_data),
        .out_valid_o(a_ov), .out_ready_i(a_or), .out_data_o(a_od),
        .count_o(a_cnt)
    );

    pipe_buf #(.DATA_W(32), .DEPTH(3)) u_dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .hold_i(1'b0), .flush_i(1'b0),
        .in_valid_i(b_iv), .in_ready_o(b_ir), .in_data_i(in_data),
        .out_valid_o(b_ov), .out_ready_i(b_or), .out_data_o(b_od),
        .count_o(b_cnt)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] qa[$];
    logic [31:0] qb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Drive one cycle on instance A; queue the expected payload when accepted.
    task automatic step_a(input logic iv, input logic [31:0] d, input logic ordy,
                          input logic hld, input logic fl);
        @(posedge clk); #1;
        a_iv = iv; in_data = d; a_or = ordy; hold = hld; flush = fl;
        #1;
        if (iv && a_ir) qa.push_back(d);
        if (fl) qa.delete();
    endtask

    task automatic step_b(input logic iv, input logic [31:0] d, input logic ordy);
        @(posedge clk); #1;
        b_iv = iv; in_data = d; b_or = ordy;
        #1;
        if (iv && b_ir) qb.push_back(d);
    endtask

    // Monitors: a pop happens at the next edge whenever valid & ready.
    always @(negedge clk) begin
        if (a_ov && a_or) begin
            if (qa.size() == 0) begin
                checks++; errors++;
                $display("FAIL a_pop: got %h, required no output", a_od);
            end else begin
                chk("a_data", a_od, qa.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (b_ov && b_or) begin
            if (qb.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_pop: got %h, required no output", b_od);
            end else begin
                chk("b_data", b_od, qb.pop_front());
            end
        end
    end

    initial begin
        rst_n = 1'b0; hold = 1'b0; flush = 1'b0; in_data = '0;
        a_iv = 1'b0; a_or = 1'b0; b_iv = 1'b0; b_or = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        chk("rst_cnt", 32'(a_cnt), 0);
        chk("rst_ov", 32'(a_ov), 0);
        chk("rst_od", a_od, 32'h13);
        chk("rst_ir", 32'(a_ir), 0);
        chk("rst_b_cnt", 32'(b_cnt), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("rel_ir", 32'(a_ir), 1);

        // Reset then stream
        step_a(1, 32'h11, 1, 0, 0);
        chk("s0_cnt", 32'(a_cnt), 0);
        chk("s0_ir", 32'(a_ir), 1);
        chk("s0_ov", 32'(a_ov), 32'(BYP));
        step_a(1, 32'h22, 1, 0, 0);
        chk("s1_cnt", 32'(a_cnt), BYP ? 0 : 1);
        chk("s1_ir", 32'(a_ir), 1);
        chk("s1_od", a_od, BYP ? 32'h22 : 32'h11);
        step_a(1, 32'h33, 1, 0, 0);
        chk("s2_cnt", 32'(a_cnt), BYP ? 0 : 1);
        chk("s2_ir", 32'(a_ir), 1);
        step_a(0, 32'h0, 1, 0, 0);
        chk("s3_cnt", 32'(a_cnt), BYP ? 0 : 1);
        step_a(0, 32'h0, 0, 0, 0);
        chk("s4_cnt", 32'(a_cnt), 0);
        chk("s4_ov", 32'(a_ov), 0);

        // Full with pop: push is refused, count drops to 1
        step_a(1, 32'hA1, 0, 0, 0);
        step_a(1, 32'hA2, 0, 0, 0);
        step_a(1, 32'hA3, 1, 0, 0);
        chk("fp_ir", 32'(a_ir), 0);
        chk("fp_cnt", 32'(a_cnt), 2);
        chk("fp_od", a_od, 32'hA1);
        step_a(0, 32'h0, 0, 0, 0);
        chk("fp_cnt_next", 32'(a_cnt), 1);
        chk("fp_od_next", a_od, 32'hA2);

        // Hold with two entries stored
        step_a(1, 32'hB1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step_a(1, 32'hEE, 1, 1, 0);
            chk("hold_ov", 32'(a_ov), 0);
            chk("hold_od", a_od, 32'h13);
            chk("hold_ir", 32'(a_ir), 0);
            chk("hold_cnt", 32'(a_cnt), 2);
        end
        step_a(0, 32'h0, 0, 0, 0);
        chk("unhold_ov", 32'(a_ov), 1);
        chk("unhold_od", a_od, 32'hA2);
        chk("unhold_cnt", 32'(a_cnt), 2);

        // Flush together with hold: flush wins
        step_a(1, 32'hEE, 1, 1, 1);
        chk("fl_ir", 32'(a_ir), 0);
        chk("fl_ov", 32'(a_ov), 0);
        step_a(0, 32'h0, 0, 0, 0);
        chk("fl_cnt", 32'(a_cnt), 0);
        chk("fl_ov_next", 32'(a_ov), 0);
        chk("fl_od_next", a_od, 32'h13);
        chk("fl_ir_next", 32'(a_ir), 1);

        // Asynchronous reset mid-stream
        step_a(1, 32'hC1, 0, 0, 0);
        step_a(1, 32'hC2, 0, 0, 0);
        step_a(0, 32'h0, 0, 0, 0);
        chk("mr_cnt_before", 32'(a_cnt), 2);
        #1;
        rst_n = 1'b0;
        #1;
        qa.delete();
        chk("mr_cnt", 32'(a_cnt), 0);
        chk("mr_ov", 32'(a_ov), 0);
        chk("mr_od", a_od, 32'h13);
        chk("mr_ir", 32'(a_ir), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("mr_rel_ir", 32'(a_ir), 1);
        chk("mr_rel_cnt", 32'(a_cnt), 0);

        // Bypass (or one-cycle latency without it)
        step_a(1, 32'h55, 1, 0, 0);
        chk("bp_ov", 32'(a_ov), 32'(BYP));
        chk("bp_od", a_od, BYP ? 32'h55 : 32'h13);
        chk("bp_cnt", 32'(a_cnt), 0);
        step_a(0, 32'h0, 1, 0, 0);
        chk("bp_cnt_next", 32'(a_cnt), BYP ? 0 : 1);
        chk("bp_ov_next", 32'(a_ov), BYP ? 0 : 1);
        chk("bp_od_next", a_od, BYP ? 32'h13 : 32'h55);
        step_a(0, 32'h0, 0, 0, 0);

        // DEPTH=3 fill and wrap
        step_b(1, 32'hA, 0);
        step_b(1, 32'hB, 0);
        step_b(1, 32'hC, 0);
        step_b(1, 32'hF, 0);
        chk("b_full_ir", 32'(b_ir), 0);
        chk("b_full_cnt", 32'(b_cnt), 3);
        step_b(0, 32'h0, 1);
        chk("b_pop1_cnt", 32'(b_cnt), 3);
        step_b(0, 32'h0, 1);
        chk("b_pop2_cnt", 32'(b_cnt), 2);
        step_b(1, 32'hD, 0);
        chk("b_d_cnt", 32'(b_cnt), 1);
        chk("b_d_ir", 32'(b_ir), 1);
        step_b(1, 32'hE, 0);
        chk("b_e_cnt", 32'(b_cnt), 2);
        step_b(0, 32'h0, 1);
        chk("b_refull_cnt", 32'(b_cnt), 3);
        chk("b_head", b_od, 32'hC);
        step_b(0, 32'h0, 1);
        step_b(0, 32'h0, 1);
        step_b(0, 32'h0, 0);
        chk("b_drain_cnt", 32'(b_cnt), 0);

        chk("qa_left", 32'(qa.size()), 0);
        chk("qb_left", 32'(qb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
